// File: rtl/new_means_calc_block_pkg.sv
// -----------------------------------------------------------------------------
// kmeans_pkg
// Shared widths, FSM state type and centroid packing helper for the k-means
// new-means calculation block.
// Optional build macro: NEW_MEANS_ROUND_NEAREST_EN widens the divider
// dividend by one bit so the mean can be rounded to nearest.
// -----------------------------------------------------------------------------
package kmeans_pkg;

    localparam int CORD_W     = 13;
    localparam int ACC_CORD_W = 22;
    localparam int CNT_W      = 10;
    localparam int CENT_NUM   = 8;
    localparam int CORD_NUM   = 7;
    localparam int SEL_W      = $clog2(CENT_NUM);
    localparam int DATA_W     = CORD_NUM * CORD_W;
    localparam int SUM_W      = CORD_NUM * ACC_CORD_W;

`ifdef NEW_MEANS_ROUND_NEAREST_EN
    localparam int DVD_W = ACC_CORD_W + 1;
`else
    localparam int DVD_W = ACC_CORD_W;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV,
        ST_EMIT,
        ST_FINISH
    } state_t;

    typedef logic [CORD_W-1:0] cord_t;

    // Coordinate k lands at [CORD_W*k +: CORD_W].
    function automatic logic [DATA_W-1:0] pack_centroid(input cord_t cords [CORD_NUM]);
        logic [DATA_W-1:0] p;
        p = '0;
        for (int k = 0; k < CORD_NUM; k++) begin
            p[k*CORD_W +: CORD_W] = cords[k];
        end
        return p;
    endfunction

endpackage

// File: rtl/new_means_calc_block_if.sv
// -----------------------------------------------------------------------------
// new_means_calc_block_if
// Controller handshake, accumulator read port and centroid output bus.
//   start / busy / done        : controller sequencing
//   accum_sel / accum_*_in     : accumulator register read (registered select)
//   new_centroid_out / cent_num / centroid_valid / last_centroid : to the
//                                convergence-check stage
// master = environment side (controller + accumulators + downstream),
// slave  = the new-means block.
// -----------------------------------------------------------------------------
interface new_means_calc_block_if;
    import kmeans_pkg::*;

    logic                 start;
    logic                 busy;
    logic                 done;
    logic [SEL_W-1:0]     accum_sel;
    logic [SUM_W-1:0]     accum_sum_in;
    logic [CNT_W-1:0]     accum_count_in;
    logic [DATA_W-1:0]    old_centroid_in;
    logic [DATA_W-1:0]    new_centroid_out;
    logic [SEL_W-1:0]     cent_num;
    logic                 centroid_valid;
    logic                 last_centroid;

    modport master (
        output start, accum_sum_in, accum_count_in, old_centroid_in,
        input  busy, done, accum_sel, new_centroid_out, cent_num,
               centroid_valid, last_centroid
    );

    modport slave (
        input  start, accum_sum_in, accum_count_in, old_centroid_in,
        output busy, done, accum_sel, new_centroid_out, cent_num,
               centroid_valid, last_centroid
    );

endinterface

// File: rtl/new_means_calc_block_serial_divider.sv
// -----------------------------------------------------------------------------
// serial_divider
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// The first iteration is performed on the i_start edge itself, so the full
// quotient is in o_quotient (and o_done is high) DVD_W-1 cycles after start.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_start       load operands and perform iteration 1
//   i_dividend    DVD_W-bit dividend
//   i_divisor     DVS_W-bit divisor (non-zero)
//   o_quotient    DVD_W-bit quotient
//   o_done        high from the final iteration until the next start
// -----------------------------------------------------------------------------
module serial_divider #(
    parameter int DVD_W = 22,
    parameter int DVS_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DVS_W-1:0] i_divisor,
    output logic [DVD_W-1:0] o_quotient,
    output logic             o_done
);

    localparam int REM_W  = DVS_W + 1;
    localparam int ITER_W = $clog2(DVD_W + 1);

    // r_dq shifts dividend bits out of the top and quotient bits in at the bottom.
    logic [DVS_W-1:0]  r_rem;
    logic [DVD_W-1:0]  r_dq;
    logic [DVS_W-1:0]  r_dvs;
    logic [ITER_W-1:0] r_iter;
    logic              r_run;
    logic              r_done;

    logic [DVS_W-1:0]  w_rem_in;
    logic [DVD_W-1:0]  w_dq_in;
    logic [DVS_W-1:0]  w_dvs_in;
    logic [REM_W-1:0]  w_shift;
    logic              w_ge;
    logic [DVS_W-1:0]  w_rem_next;
    logic              w_last;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        w_rem_in   = i_start ? '0 : r_rem;
        w_dq_in    = i_start ? i_dividend : r_dq;
        w_dvs_in   = i_start ? i_divisor : r_dvs;
        w_shift    = {w_rem_in, w_dq_in[DVD_W-1]};
        w_ge       = (w_shift >= {1'b0, w_dvs_in});
        // A restored remainder is always below the divisor, so it fits DVS_W bits.
        w_rem_next = w_ge ? DVS_W'(w_shift - {1'b0, w_dvs_in}) : w_shift[DVS_W-1:0];
        w_last     = !i_start && (r_iter == ITER_W'(DVD_W - 1));
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_dq   <= '0;
            r_dvs  <= '0;
            r_iter <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else if (i_start || r_run) begin
            r_rem  <= w_rem_next;
            r_dq   <= {w_dq_in[DVD_W-2:0], w_ge};
            r_dvs  <= w_dvs_in;
            r_iter <= i_start ? ITER_W'(1) : r_iter + 1'b1;
            r_run  <= !w_last;
            r_done <= w_last;
        end
    end

    assign o_quotient = r_dq;
    assign o_done     = r_done;

endmodule

// File: rtl/new_means_calc_block.sv
// -----------------------------------------------------------------------------
// new_means_calc_block
// For each of CENT_NUM clusters: reads the coordinate sums and member count,
// divides every sum by the count with CORD_NUM parallel serial dividers and
// emits the new centroid with a one-cycle centroid_valid strobe. Empty
// clusters keep their old centroid. done pulses once after the last cluster.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        new_means_calc_block_if.slave (handshake, accumulator read,
//              centroid output)
// Optional build macro: NEW_MEANS_ROUND_NEAREST_EN -- dividend becomes
// sum + count/2 (one bit wider), giving round-to-nearest means and one
// extra divide cycle per cluster.
// -----------------------------------------------------------------------------
module new_means_calc_block
    import kmeans_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    new_means_calc_block_if.slave  bus
);

    state_t              r_state;
    state_t              w_next;
    logic [SEL_W-1:0]    r_sel;
    logic [DATA_W-1:0]   r_cent_out;
    logic [SEL_W-1:0]    r_cent_num;

    logic                w_count_zero;
    logic                w_launch;
    logic [CORD_NUM-1:0] w_div_done;
    logic                w_all_done;
    logic                w_last_idx;
    cord_t               w_cords [CORD_NUM];

    logic                w_busy;
    logic                w_done;
    logic                w_valid;
    logic                w_last_cent;

    assign w_count_zero = (bus.accum_count_in == '0);
    assign w_launch     = (r_state == ST_LOAD) && !w_count_zero;
    assign w_all_done   = &w_div_done;
    assign w_last_idx   = (r_sel == SEL_W'(CENT_NUM - 1));

    // Dividers read the accumulator directly; the LOAD edge is their capture edge.
    for (genvar k = 0; k < CORD_NUM; k++) begin : g_div
        logic [ACC_CORD_W-1:0] w_sum;
        logic [DVD_W-1:0]      w_dvd;
        logic [DVD_W-1:0]      w_q;

        assign w_sum = bus.accum_sum_in[k*ACC_CORD_W +: ACC_CORD_W];
`ifdef NEW_MEANS_ROUND_NEAREST_EN
        assign w_dvd = {1'b0, w_sum} + DVD_W'(bus.accum_count_in >> 1);
`else
        assign w_dvd = w_sum;
`endif

        serial_divider #(
            .DVD_W (DVD_W),
            .DVS_W (CNT_W)
        ) u_div (
            .clk        (clk),
            .rst        (rst),
            .i_start    (w_launch),
            .i_dividend (w_dvd),
            .i_divisor  (bus.accum_count_in),
            .o_quotient (w_q),
            .o_done     (w_div_done[k])
        );

        // Quotients wider than a coordinate saturate instead of wrapping.
        assign w_cords[k] = (|w_q[DVD_W-1:CORD_W]) ? '1 : w_q[CORD_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_valid     = 1'b0;
        w_last_cent = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) w_next = ST_LOAD;
            end
            ST_LOAD:   w_next = w_count_zero ? ST_EMIT : ST_DIV;
            ST_DIV:    if (w_all_done) w_next = ST_EMIT;
            ST_EMIT: begin
                w_valid     = 1'b1;
                w_last_cent = w_last_idx;
                w_next      = w_last_idx ? ST_FINISH : ST_LOAD;
            end
            ST_FINISH: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default:   w_next = ST_IDLE;
        endcase
    end

    // Output registers load on the edge entering EMIT, so data and strobe align.
    // NOTE: datapath registers are reset too, since their reset values are visible outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel      <= '0;
            r_cent_out <= '0;
            r_cent_num <= '0;
        end else begin
            if ((r_state == ST_IDLE) && bus.start) begin
                r_sel <= '0;
            end else if ((r_state == ST_EMIT) && !w_last_idx) begin
                r_sel <= r_sel + 1'b1;
            end

            if ((r_state == ST_LOAD) && w_count_zero) begin
                r_cent_out <= bus.old_centroid_in;
                r_cent_num <= r_sel;
            end else if ((r_state == ST_DIV) && w_all_done) begin
                r_cent_out <= pack_centroid(w_cords);
                r_cent_num <= r_sel;
            end
        end
    end

    assign bus.busy             = w_busy;
    assign bus.done             = w_done;
    assign bus.centroid_valid   = w_valid;
    assign bus.last_centroid    = w_last_cent;
    assign bus.accum_sel        = r_sel;
    assign bus.new_centroid_out = r_cent_out;
    assign bus.cent_num         = r_cent_num;

endmodule

// File: tb/tb_new_means_calc_block.sv
// -----------------------------------------------------------------------------
// tb_new_means_calc_block
// Self-checking bench: an accumulator array drives the block, a reference
// model computes each centroid (mean, rounding, saturation, empty-cluster
// rule) and its strobe cycle from the cluster latencies.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_new_means_calc_block;
    import kmeans_pkg::*;

`ifdef NEW_MEANS_ROUND_NEAREST_EN
    localparam bit ROUND    = 1'b1;
    localparam int DIV_CYCS = 23;
`else
    localparam bit ROUND    = 1'b0;
    localparam int DIV_CYCS = 22;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    new_means_calc_block_if bus();

    new_means_calc_block dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [ACC_CORD_W-1:0] sums [CENT_NUM][CORD_NUM];
    logic [CNT_W-1:0]      cnts [CENT_NUM];
    logic [CORD_W-1:0]     olds [CENT_NUM][CORD_NUM];

    int n_checks = 0;
    int n_errors = 0;

    // Accumulator register file, indexed by the block's select.
    always_comb begin
        bus.accum_sum_in    = '0;
        bus.old_centroid_in = '0;
        for (int k = 0; k < CORD_NUM; k++) begin
            bus.accum_sum_in[k*ACC_CORD_W +: ACC_CORD_W] = sums[bus.accum_sel][k];
            bus.old_centroid_in[k*CORD_W +: CORD_W]      = olds[bus.accum_sel][k];
        end
        bus.accum_count_in = cnts[bus.accum_sel];
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_centroid(input int c);
        logic [DATA_W-1:0] e;
        longint q;
        e = '0;
        for (int k = 0; k < CORD_NUM; k++) begin
            if (cnts[c] == 0) begin
                q = longint'(olds[c][k]);
            end else begin
                q = longint'(sums[c][k]);
                if (ROUND) q = q + longint'(cnts[c]) / 2;
                q = q / longint'(cnts[c]);
                if (q > 8191) q = 8191;
            end
            e[k*CORD_W +: CORD_W] = CORD_W'(q);
        end
        return e;
    endfunction

    task automatic fill_random();
        for (int c = 0; c < CENT_NUM; c++) begin
            cnts[c] = ($urandom_range(0, 7) == 0) ? '0 : CNT_W'($urandom_range(1, 1023));
            for (int k = 0; k < CORD_NUM; k++) begin
                sums[c][k] = ACC_CORD_W'($urandom_range(0, 4194303));
                olds[c][k] = CORD_W'($urandom_range(0, 8191));
            end
        end
    endtask

    // One full pass from start; restart_cyc re-pulses start mid-pass (0 = never).
    task automatic run_pass(input string name, input int restart_cyc);
        int exp_cyc [CENT_NUM];
        logic [DATA_W-1:0] exp_data [CENT_NUM];
        int got_cyc [CENT_NUM];
        logic [DATA_W-1:0] got_data [CENT_NUM];
        logic [SEL_W-1:0] got_num [CENT_NUM];
        logic got_last [CENT_NUM];
        int t, exp_done, cyc, n_str, n_done, done_cyc, bad_last;

        t = 0;
        for (int c = 0; c < CENT_NUM; c++) begin
            t = t + ((cnts[c] == 0) ? 2 : DIV_CYCS + 2);
            exp_cyc[c]  = t;
            exp_data[c] = exp_centroid(c);
            got_cyc[c]  = -1;
            got_data[c] = '0;
            got_num[c]  = '0;
            got_last[c] = 1'b0;
        end
        exp_done = t + 1;
        n_str = 0; n_done = 0; done_cyc = -1; bad_last = 0;

        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc = 0;
        while (cyc < exp_done + 3 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            bus.start = (cyc == restart_cyc);
            if (cyc == 1)            check({name, "_busy_start"}, bus.busy, 1'b1);
            if (cyc == exp_done)     check({name, "_busy_finish"}, bus.busy, 1'b1);
            if (cyc == exp_done + 1) check({name, "_busy_after"}, bus.busy, 1'b0);
            if (bus.centroid_valid) begin
                if (n_str < CENT_NUM) begin
                    got_cyc[n_str]  = cyc;
                    got_data[n_str] = bus.new_centroid_out;
                    got_num[n_str]  = bus.cent_num;
                    got_last[n_str] = bus.last_centroid;
                end
                n_str++;
            end
            if (bus.last_centroid && !(bus.centroid_valid && bus.cent_num == 3'd7)) bad_last++;
            if (bus.done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
        bus.start = 1'b0;

        check({name, "_strobes"}, n_str, CENT_NUM);
        check({name, "_done_pulses"}, n_done, 1);
        check({name, "_done_cycle"}, done_cyc, exp_done);
        check({name, "_last_only_7"}, bad_last, 0);
        for (int c = 0; c < CENT_NUM; c++) begin
            check($sformatf("%s_cyc%0d", name, c), got_cyc[c], exp_cyc[c]);
            check($sformatf("%s_num%0d", name, c), got_num[c], c);
            check($sformatf("%s_data%0d", name, c), got_data[c], exp_data[c]);
            check($sformatf("%s_last%0d", name, c), got_last[c], (c == CENT_NUM - 1));
        end
        check({name, "_hold_num"}, bus.cent_num, 3'd7);
        check({name, "_hold_data"}, bus.new_centroid_out, exp_data[CENT_NUM-1]);
    endtask

    // Starts a pass and asserts reset at rst_cyc; no done may follow.
    task automatic run_reset_pass(input int rst_cyc);
        int cyc, n_done;
        n_done = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc = 0;
        while (cyc < rst_cyc) begin
            @(negedge clk);
            cyc++;
            if (bus.done) n_done++;
        end
        check("rstmid_busy_before", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rstmid_busy", bus.busy, 1'b0);
        check("rstmid_valid", bus.centroid_valid, 1'b0);
        check("rstmid_data", bus.new_centroid_out, '0);
        check("rstmid_sel", bus.accum_sel, '0);
        repeat (3) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done || bus.centroid_valid) n_done++;
        end
        check("rstmid_no_done", n_done, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        for (int c = 0; c < CENT_NUM; c++) begin
            cnts[c] = 10'd1;
            for (int k = 0; k < CORD_NUM; k++) begin
                sums[c][k] = '0;
                olds[c][k] = '0;
            end
        end

        repeat (3) @(negedge clk);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_valid", bus.centroid_valid, 1'b0);
        check("reset_last", bus.last_centroid, 1'b0);
        check("reset_sel", bus.accum_sel, '0);
        check("reset_num", bus.cent_num, '0);
        check("reset_data", bus.new_centroid_out, '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Cluster 0 mean 100 everywhere, the rest zero.
        cnts[0] = 10'd7;
        for (int k = 0; k < CORD_NUM; k++) sums[0][k] = 22'd700;
        run_pass("basic", 0);

        // Truncate vs round, empty cluster, saturation, and an ignored restart.
        fill_random();
        cnts[1] = 10'd4;
        cnts[3] = 10'd0;
        cnts[5] = 10'd1;
        for (int k = 0; k < CORD_NUM; k++) begin
            sums[1][k] = 22'd23;
            olds[3][k] = CORD_W'(k + 1);
            sums[5][k] = 22'h3FFFFF;
        end
        run_pass("edge", 50);

        repeat (3) begin
            fill_random();
            run_pass("rand", $urandom_range(2, 150));
        end

        fill_random();
        for (int c = 0; c < CENT_NUM; c++) if (cnts[c] == 0) cnts[c] = 10'd3;
        run_reset_pass(100);
        run_pass("after_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
